// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises the CPU instruction-fetch and data ports onto
// one single-ported, variable-latency memory via a req/ack handshake.
// Data accesses have fixed priority over fetches; each completed access
// returns a one-cycle ready pulse to its requester. `stall` holds the
// pipeline while either requester is still waiting.
module mem_port_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // instruction-fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  // data port
  input  logic          d_read_en,
  input  logic          d_write_en,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  // memory port
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  // pipeline control / status
  output logic          stall,
  output logic          err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BUSY_D = 3'd1;
  localparam logic [2:0] BUSY_I = 3'd2;
  localparam logic [2:0] RESP_D = 3'd3;
  localparam logic [2:0] RESP_I = 3'd4;

  logic [2:0] state;
  logic       d_req;

  assign d_req = d_read_en | d_write_en;

  // Ready pulses are decoded from the RESP states, so an async reset
  // mid-access can never leave a stray ready behind.
  assign if_ready = (state == RESP_I);
  assign d_ready  = (state == RESP_D);

  // Pipeline hold while any requester has not yet been answered.
  assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

  // Arbitration FSM, latched memory request fields and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      // Simultaneous load+store is a pipeline bug; it is served as a store
      // and flagged until the next reset.
      if (d_read_en && d_write_en) begin
        err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (d_req) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_write_en;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (if_req) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            mem_req <= 1'b0;
            state   <= RESP_D;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            if_rdata <= mem_rdata;
            mem_req  <= 1'b0;
            state    <= RESP_I;
          end
        end
        // Requester is ineligible during its RESP cycle, so a held request
        // is only re-arbitrated from IDLE.
        RESP_D, RESP_I: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
